// File: rtl/fcl_rc_pkg.sv
// Shared definitions for the RC supervisor: state encoding, register map,
// register reset values and the signed threshold/clamp helpers.
package fcl_rc_pkg;

  localparam int NUM_CH = 6;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARMING    = 3'd1,
    ST_ARMED     = 3'd2,
    ST_DISARMING = 3'd3,
    ST_FAILSAFE  = 3'd4
  } rc_state_e;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_TIMEOUT  = 3'd1;
  localparam logic [2:0] REG_ARM_THR  = 3'd2;
  localparam logic [2:0] REG_ARM_HOLD = 3'd3;
  localparam logic [2:0] REG_LIMIT    = 3'd4;
  localparam logic [2:0] REG_CONTROL  = 3'd5;

  localparam logic [7:0]  DEF_TIMEOUT  = 8'd50;
  localparam logic [14:0] DEF_ARM_THR  = 15'd16000;
  localparam logic [11:0] DEF_ARM_HOLD = 12'd1000;
  localparam logic [14:0] DEF_LIMIT    = 15'd25600;
  localparam logic [7:0]  WD_MAX       = 8'd255;

  // Comparisons are done at 17 bits so -thr never overflows.
  function automatic logic below_neg(input logic [15:0] v, input logic [14:0] thr);
    return $signed({v[15], v}) < -$signed({2'b00, thr});
  endfunction

  function automatic logic above_pos(input logic [15:0] v, input logic [14:0] thr);
    return $signed({v[15], v}) > $signed({2'b00, thr});
  endfunction

  function automatic logic [15:0] clamp_lim(input logic [15:0] v, input logic [14:0] lim);
    logic signed [16:0] vx, hi, lo;
    vx = $signed({v[15], v});
    hi = $signed({2'b00, lim});
    lo = -hi;
    if (vx > hi)      return hi[15:0];
    else if (vx < lo) return lo[15:0];
    else              return v;
  endfunction

endpackage

// File: rtl/fcl_rc_watchdog.sv
// One receiver channel: 2-flop synchroniser, falling-edge detect and a
// saturating millisecond counter that flags the channel lost.
module fcl_rc_watchdog
  import fcl_rc_pkg::*;
(
  input  logic       clk_in,
  input  logic       _reset_in,
  input  logic       pwm,
  input  logic       tick,
  input  logic [7:0] timeout,
  output logic       lost
);

  // sync[1:0] is the synchroniser, sync[2] the previous synchronised value
  logic [2:0] sync;
  logic       fall;
  logic [7:0] wd;

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) sync <= '0;
    else            sync <= {sync[1:0], pwm};
  end

  assign fall = sync[2] & ~sync[1];

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in)                wd <= WD_MAX;
    else if (fall)                 wd <= '0;
    else if (tick && wd != WD_MAX) wd <= wd + 8'd1;
  end

  assign lost = (timeout != '0) && (wd >= timeout);

endmodule

// File: rtl/fcl_rc_supervisor.sv
// RC link supervisor: per-channel loss watchdogs, stick-gesture arming FSM,
// clamped command outputs and an RBUS register block.
module fcl_rc_supervisor
  import fcl_rc_pkg::*;
#(
  parameter int INPUT_CLOCK_SPEED = 125000000,
  parameter int RBUS_ADDR_WIDTH   = 16,
  parameter int RBUS_DATA_WIDTH   = 16,
  parameter int RBUS_OFFSET       = 0
) (
  input  logic                       clk_in,
  input  logic                       _reset_in,
  input  logic [NUM_CH-1:0]          pwm_in,
  input  logic signed [15:0]         pwm_1_in,
  input  logic signed [15:0]         pwm_2_in,
  input  logic signed [15:0]         pwm_3_in,
  input  logic signed [15:0]         pwm_4_in,
  input  logic signed [15:0]         pwm_5_in,
  input  logic signed [15:0]         pwm_6_in,
  output logic signed [15:0]         cmd_1_out,
  output logic signed [15:0]         cmd_2_out,
  output logic signed [15:0]         cmd_3_out,
  output logic signed [15:0]         cmd_4_out,
  output logic signed [15:0]         cmd_5_out,
  output logic signed [15:0]         cmd_6_out,
  output logic                       armed_out,
  output logic                       failsafe_out,
  output logic                       link_ok_out,
  output logic [RBUS_DATA_WIDTH-1:0] rbus_data_out,
  input  logic [RBUS_DATA_WIDTH-1:0] rbus_data_in,
  input  logic [RBUS_ADDR_WIDTH-1:0] rbus_addr_in,
  input  logic                       rbus_read_in,
  input  logic                       rbus_write_in,
  output logic                       rbus_ack_out
);

  localparam int TICK_DIV = (INPUT_CLOCK_SPEED / 1000 < 1) ? 1 : INPUT_CLOCK_SPEED / 1000;

  logic [NUM_CH-1:0][15:0] pwm, cmd;
  logic [NUM_CH-1:0]       lost;
  logic [31:0]             tick_cnt;
  logic                    tick, link_ok;
  logic [7:0]              timeout_r;
  logic [14:0]             arm_thr_r, limit_r;
  logic [11:0]             arm_hold_r, hold_cnt;
  rc_state_e               state, state_nxt;

  assign pwm = {pwm_6_in, pwm_5_in, pwm_4_in, pwm_3_in, pwm_2_in, pwm_1_in};

  // 1 ms tick
  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in)  tick_cnt <= '0;
    else if (tick)   tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 32'd1;
  end
  assign tick = (tick_cnt == 32'(TICK_DIV - 1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_wd
    fcl_rc_watchdog u_wd (
      .clk_in    (clk_in),
      ._reset_in (_reset_in),
      .pwm       (pwm_in[i]),
      .tick      (tick),
      .timeout   (timeout_r),
      .lost      (lost[i])
    );
  end

  assign link_ok = ~|lost;

  // RBUS decode relative to the base address
  logic [RBUS_ADDR_WIDTH-1:0] rel;
  logic [2:0]                 idx;
  logic                       in_win, rd_hit, wr_hit, force_disarm;
  logic [15:0]                rdata;
  logic                       unused_data;

  assign rel          = rbus_addr_in - RBUS_ADDR_WIDTH'(RBUS_OFFSET);
  assign in_win       = (rel[RBUS_ADDR_WIDTH-1:3] == '0);
  assign idx          = rel[2:0];
  assign rd_hit       = in_win && (idx <= REG_LIMIT);
  assign wr_hit       = in_win && (idx >= REG_TIMEOUT) && (idx <= REG_CONTROL);
  assign rbus_ack_out = (rbus_read_in & rd_hit) | (rbus_write_in & wr_hit);
  assign force_disarm = rbus_write_in && in_win && (idx == REG_CONTROL) && rbus_data_in[0];
  assign unused_data  = ^rbus_data_in;

  always_comb begin
    rdata = '0;
    if (rbus_read_in && in_win) begin
      case (idx)
        REG_STATUS:   rdata = {2'b00, lost, 5'b00000, state};
        REG_TIMEOUT:  rdata = {8'h00, timeout_r};
        REG_ARM_THR:  rdata = {1'b0, arm_thr_r};
        REG_ARM_HOLD: rdata = {4'h0, arm_hold_r};
        REG_LIMIT:    rdata = {1'b0, limit_r};
        default:      rdata = '0;
      endcase
    end
  end
  assign rbus_data_out = RBUS_DATA_WIDTH'(rdata);

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) begin
      timeout_r  <= DEF_TIMEOUT;
      arm_thr_r  <= DEF_ARM_THR;
      arm_hold_r <= DEF_ARM_HOLD;
      limit_r    <= DEF_LIMIT;
    end else if (rbus_write_in && in_win) begin
      case (idx)
        REG_TIMEOUT:  timeout_r  <= rbus_data_in[7:0];
        REG_ARM_THR:  arm_thr_r  <= rbus_data_in[14:0];
        REG_ARM_HOLD: arm_hold_r <= rbus_data_in[11:0];
        REG_LIMIT:    limit_r    <= rbus_data_in[14:0];
        default: ;
      endcase
    end
  end

  // Gestures and arming FSM
  logic ch1_low, arm_g, disarm_g, hold_done;
  assign ch1_low   = below_neg(pwm[0], arm_thr_r);
  assign arm_g     = ch1_low & above_pos(pwm[3], arm_thr_r);
  assign disarm_g  = ch1_low & below_neg(pwm[3], arm_thr_r);
  assign hold_done = (hold_cnt == arm_hold_r);

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) state <= ST_DISARMED;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DISARMED:  if (arm_g && link_ok) state_nxt = ST_ARMING;
      ST_ARMING:    if (!arm_g || !link_ok) state_nxt = ST_DISARMED;
                    else if (hold_done)     state_nxt = ST_ARMED;
      ST_ARMED:     if (!link_ok)           state_nxt = ST_FAILSAFE;
                    else if (disarm_g)      state_nxt = ST_DISARMING;
      ST_DISARMING: if (!link_ok)           state_nxt = ST_FAILSAFE;
                    else if (!disarm_g)     state_nxt = ST_ARMED;
                    else if (hold_done)     state_nxt = ST_DISARMED;
      ST_FAILSAFE:  if (link_ok && ch1_low) state_nxt = ST_DISARMED;
      default:                              state_nxt = ST_DISARMED;
    endcase
    if (force_disarm) state_nxt = ST_DISARMED;
  end

  always_comb begin
    armed_out    = (state == ST_ARMED) || (state == ST_DISARMING);
    failsafe_out = (state == ST_FAILSAFE);
  end

  // Hold counter restarts on any state change and saturates instead of wrapping
  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in)                 hold_cnt <= '0;
    else if (state_nxt != state)    hold_cnt <= '0;
    else if (tick && hold_cnt != '1) hold_cnt <= hold_cnt + 12'd1;
  end

  // Commands follow the next state so they are non-zero exactly while armed
  logic armed_nxt;
  assign armed_nxt = (state_nxt == ST_ARMED) || (state_nxt == ST_DISARMING);

  always_ff @(posedge clk_in or negedge _reset_in) begin
    if (!_reset_in) begin
      cmd         <= '0;
      link_ok_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        cmd[i] <= armed_nxt ? clamp_lim(pwm[i], limit_r) : 16'd0;
      link_ok_out <= link_ok;
    end
  end

  assign cmd_1_out = cmd[0];
  assign cmd_2_out = cmd[1];
  assign cmd_3_out = cmd[2];
  assign cmd_4_out = cmd[3];
  assign cmd_5_out = cmd[4];
  assign cmd_6_out = cmd[5];

endmodule

// File: doc/fcl_rc_supervisor.md
FCL_RC_SUPERVISOR -- requirements
Module: fcl_rc_supervisor

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_SPEED, default 125000000, clk_in frequency in Hz.
REQ-002 SHALL have parameter RBUS_ADDR_WIDTH, default 16, RBUS address width.
REQ-003 SHALL have parameter RBUS_DATA_WIDTH, default 16, RBUS data width (>=16).
REQ-004 SHALL have parameter RBUS_OFFSET, default 0, RBUS base address.
REQ-005 SHALL have port clk_in  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port _reset_in  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pwm_in  input  6  raw receiver pulses, asynchronous; bit n is channel n+1.
REQ-008 SHALL have ports pwm_1_in..pwm_6_in  input  16 each, signed  decoded channel values from the PWM decoder.
REQ-009 SHALL have ports cmd_1_out..cmd_6_out  output  16 each, signed  supervised commands.
REQ-010 SHALL have ports armed_out, failsafe_out, link_ok_out  output  1 each  status flags.
REQ-011 SHALL have ports rbus_data_out (out, RBUS_DATA_WIDTH), rbus_data_in (in, RBUS_DATA_WIDTH), rbus_addr_in (in, RBUS_ADDR_WIDTH), rbus_read_in (in, 1), rbus_write_in (in, 1), rbus_ack_out (out, 1).

Function
REQ-012 SHALL synchronise each pwm_in bit through 2 flops, then detect falling edges on the synchronised signal.
REQ-013 SHALL generate a 1 ms tick: one-cycle pulse every INPUT_CLOCK_SPEED/1000 cycles.
REQ-014 SHALL keep an 8-bit per-channel watchdog: cleared on a falling edge, +1 per tick, saturating at 255; on simultaneous edge and tick, clear wins.
REQ-015 SHALL flag channel n lost when watchdog >= TIMEOUT; TIMEOUT=0 disables loss detection; link_ok = no channel lost.
REQ-016 SHALL implement states DISARMED, ARMING, ARMED, DISARMING, FAILSAFE.
REQ-017 Arm gesture: pwm_1_in < -ARM_THR and pwm_4_in > +ARM_THR, signed, strict compare.
REQ-018 Disarm gesture: pwm_1_in < -ARM_THR and pwm_4_in < -ARM_THR.
REQ-019 DISARMED->ARMING on arm gesture with link_ok; ARMING: hold counter +1 per tick; ->ARMED when count = ARM_HOLD; gesture released or link lost -> DISARMED.
REQ-020 ARMED->DISARMING on disarm gesture; DISARMING -> DISARMED at count = ARM_HOLD; release -> ARMED.
REQ-021 ARMED or DISARMING with link lost -> FAILSAFE, taking priority over gesture progress.
REQ-022 FAILSAFE -> DISARMED only when link_ok and pwm_1_in < -ARM_THR in the same cycle; never directly to ARMED.
REQ-023 A force-disarm write moves any state to DISARMED next cycle, overriding every other transition.
REQ-024 In ARMED/DISARMING, cmd_n_out SHALL equal pwm_n_in clamped to [-LIMIT, +LIMIT], registered, 1-cycle latency; in all other states cmd_n_out = 0.
REQ-025 armed_out = state in {ARMED, DISARMING}; failsafe_out = state is FAILSAFE; link_ok_out registered.
REQ-026 Registers at RBUS_OFFSET+: 0 STATUS RO {lost[5:0] at bits 13:8, state[2:0] at bits 2:0}; 1 TIMEOUT ms (8b, default 50); 2 ARM_THR (15b unsigned, default 16000); 3 ARM_HOLD ms (12b, default 1000); 4 LIMIT (15b, default 25600); 5 CONTROL WO, bit0 force-disarm, self-clearing.
REQ-027 RBUS read is combinational: rbus_ack_out = rbus_read_in on addresses 0-4; other addresses return 0, ack 0.
REQ-028 RBUS write is captured on the clock edge; rbus_ack_out = rbus_write_in on addresses 1-5.
REQ-029 A hold counter SHALL clear on every state entry; changing ARM_HOLD mid-hold takes effect on the next compare.

Reset
REQ-030 On reset, all cmd outputs, armed_out, failsafe_out and link_ok_out SHALL be 0; state DISARMED.
REQ-031 On reset, watchdogs SHALL be 255 (lost), counters 0 and registers at their defaults.
REQ-032 Reset asserted mid-operation SHALL force outputs to 0 immediately, without waiting for a clock edge.

Structure
REQ-033 Package fcl_rc_pkg SHALL hold the state encoding, register offsets and register defaults.
REQ-034 Sub-module fcl_rc_watchdog (sync, edge detect, saturating counter, lost compare) SHALL be instantiated 6x.

Verification
REQ-035 Pulses on all channels every 20 ms, reset released -> link_ok_out=1 after the first edges; stop ch3 -> lost within 50 ms (+1 tick); STATUS bit 10 = 1.
REQ-036 ch1=-20000, ch4=+20000 held 1000 ms -> armed_out=1; release at 999 ms -> back to DISARMED, armed_out=0.
REQ-037 Armed, ch2=30000 -> cmd_2_out=25600 one cycle later; ch2=-30000 -> -25600; ch2=1234 -> 1234.
REQ-038 Armed, stop all pulses -> failsafe_out=1, cmds=0; resume with ch1=0 -> stays FAILSAFE; ch1=-20000 -> DISARMED.
REQ-039 Armed, write CONTROL=1 during the disarm gesture -> DISARMED next cycle; read CONTROL -> ack 0.
REQ-040 Write TIMEOUT=0, stop pulses -> link_ok_out stays 1.
